// File: rtl/referee_4to1_arb.sv
// -----------------------------------------------------------------------------
// referee_4to1_arb
//
// Purpose
//   Drains four source FIFOs into one destination FIFO. At most one word moves
//   per clock. A grant register selects the queue being served. The burst
//   counter limits one queue to BURST_LEN back-to-back pops before the grant
//   moves on.
//
//   Default build: round-robin. When a burst ends or the granted queue runs
//   dry, the next queue is the first non-empty one in the order g+1, g+2,
//   g+3, g (mod 4).
//   With REFEREE_STRICT_PRIO_EN defined: at the same decision points the
//   grant goes to the lowest-index non-empty queue. BURST_LEN still bounds
//   each grant.
//
// Parameters
//   LINE_SIZE  data word width in bits
//   BURST_LEN  max consecutive pops to one queue before re-arbitration (1..15)
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-high reset
//   empty_signal[3:0]   bit i high: source FIFO i is empty
//   data_in             FIFO i read data on [i*LINE_SIZE +: LINE_SIZE]; valid
//                       the cycle after its pop
//   almost_full_signal  destination can take at most 2 more words
//   pop_signal[3:0]     registered one-hot-or-zero read strobe
//   push_signal         registered write strobe to the destination
//   data_out            registered word written with push_signal
//   grant_id            queue index that sourced data_out
//   dbg_state_o         FSM state (0 = IDLE, 1 = SERVE)
//   dbg_grant_o         grant register g
//   dbg_count_o         burst counter
//
// Handshake
//   pop_signal[i] high in cycle k reads one word from FIFO i. That word is on
//   data_in in cycle k+1. It is written out with push_signal in cycle k+2,
//   carrying grant_id = i. No backpressure reaches words already popped: the
//   almost_full margin of 2 covers the two words that can be in flight.
// -----------------------------------------------------------------------------
module referee_4to1_arb #(
   parameter int LINE_SIZE = 12,
   parameter int BURST_LEN = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             empty_signal,
   input  logic [4*LINE_SIZE-1:0] data_in,
   input  logic                   almost_full_signal,
   output logic [3:0]             pop_signal,
   output logic                   push_signal,
   output logic [LINE_SIZE-1:0]   data_out,
   output logic [1:0]             grant_id,
   output logic                   dbg_state_o,
   output logic [1:0]             dbg_grant_o,
   output logic [3:0]             dbg_count_o
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SERVE = 1'b1
   } state_t;

   localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t               state_q, state_d;
   logic [1:0]           g_q, g_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [3:0]           pop_q, pop_d;

   // Read-return stage: a pop issued last cycle has its data on data_in now.
   logic                 rd_vld_q;
   logic [1:0]           rd_id_q;

   // Output stage
   logic                 push_q;
   logic [LINE_SIZE-1:0] data_q;
   logic [1:0]           gid_q;

   logic [3:0]           avail;
   logic                 any_avail;
   logic [1:0]           idle_pick;
   logic [1:0]           rot_pick;
   logic [LINE_SIZE-1:0] rd_word;

   assign avail     = ~empty_signal;
   assign any_avail = |avail;

   // First requesting queue, scanning start, start+1, start+2, start+3 (mod 4).
   // Falls back to start when nothing requests. Callers only use the result
   // when any_avail is set.
   function automatic logic [1:0] search_from(input logic [1:0] start,
                                              input logic [3:0] req);
      logic [1:0] pick;
      logic [1:0] idx;
      logic       found;
      pick  = start;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = start + 2'(k);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // ---------------------------------------------------------------------
   // Queue selection policy
   // ---------------------------------------------------------------------
`ifdef REFEREE_STRICT_PRIO_EN
   // Lowest index wins on entry from IDLE and at every re-arbitration point.
   assign idle_pick = search_from(2'd0, avail);
   assign rot_pick  = search_from(2'd0, avail);
`else
   // Leaving IDLE, the scan starts at g itself. After reset this resumes
   // from queue 0. After a drain it resumes from the last queue served.
   // Mid-service rotation starts one past g, so g is considered last.
   assign idle_pick = search_from(g_q, avail);
   assign rot_pick  = search_from(g_q + 2'd1, avail);
`endif

   // ---------------------------------------------------------------------
   // FSM: next state, grant, counter and the pop for the next cycle
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      cnt_d   = cnt_q;
      pop_d   = 4'b0000;

      case (state_q)
         ST_IDLE: begin
            if (any_avail) begin
               state_d = ST_SERVE;
               g_d     = idle_pick;
               cnt_d   = 4'd0;
            end
         end

         ST_SERVE: begin
            if (almost_full_signal) begin
               // Destination nearly full: freeze grant and counter, no pop.
               pop_d = 4'b0000;
            end else if (avail[g_q] && (cnt_q < BURST_MAX)) begin
               pop_d = 4'b0001 << g_q;
               cnt_d = cnt_q + 4'd1;
            end else if (any_avail) begin
               // Burst spent or granted queue dry. Hand over in this same
               // decision so the new queue's pop directly follows the last
               // pop of the old one. The new burst starts from zero, and
               // this pop is its first.
               g_d   = rot_pick;
               pop_d = 4'b0001 << rot_pick;
               cnt_d = 4'd1;
            end else begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Read-data slice of the queue popped last cycle
   // ---------------------------------------------------------------------
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < 4; i++) begin
         if (rd_id_q == 2'(i)) begin
            rd_word = data_in[i*LINE_SIZE +: LINE_SIZE];
         end
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         g_q      <= 2'd0;
         cnt_q    <= 4'd0;
         pop_q    <= 4'b0000;
         rd_vld_q <= 1'b0;
         rd_id_q  <= 2'd0;
         push_q   <= 1'b0;
         data_q   <= '0;
         gid_q    <= 2'd0;
      end else begin
         state_q  <= state_d;
         g_q      <= g_d;
         cnt_q    <= cnt_d;
         pop_q    <= pop_d;

         // pop_q is one-hot or zero, so an OR-encode gives its index.
         rd_vld_q <= |pop_q;
         rd_id_q  <= {pop_q[3] | pop_q[2], pop_q[3] | pop_q[1]};

         // Every push traces back to a pop two cycles earlier. Reset
         // clears rd_vld_q, which drops any word still in flight.
         push_q   <= rd_vld_q;
         if (rd_vld_q) begin
            data_q <= rd_word;
            gid_q  <= rd_id_q;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign pop_signal  = pop_q;
   assign push_signal = push_q;
   assign data_out    = data_q;
   assign grant_id    = gid_q;

   assign dbg_state_o = state_q;
   assign dbg_grant_o = g_q;
   assign dbg_count_o = cnt_q;

endmodule

// File: tb/tb_referee_4to1_arb.sv
// -----------------------------------------------------------------------------
// tb_referee_4to1_arb
//
// Bench for referee_4to1_arb. It has four source FIFOs and a burst-level model
// of the arbitration policy. The model turns queue fill levels into the pop
// order. A scoreboard matches each push to its pop, two cycles later. Build
// with REFEREE_STRICT_PRIO_EN defined to check the strict-priority variant.
// -----------------------------------------------------------------------------
module tb_referee_4to1_arb;

   localparam int W  = 12;
   localparam int BL = 4;

   logic           clk   = 1'b0;
   logic           reset = 1'b1;
   logic [3:0]     empty_signal;
   logic [4*W-1:0] data_in = '0;
   logic           almost_full_signal = 1'b0;
   logic [3:0]     pop_signal;
   logic           push_signal;
   logic [W-1:0]   data_out;
   logic [1:0]     grant_id;
   logic           dbg_state_o;
   logic [1:0]     dbg_grant_o;
   logic [3:0]     dbg_count_o;

   int checks = 0;
   int errors = 0;

   // ------------------------------------------------------------ clock/reset
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   referee_4to1_arb #(.LINE_SIZE(W), .BURST_LEN(BL)) dut (
      .clk                (clk),
      .reset              (reset),
      .empty_signal       (empty_signal),
      .data_in            (data_in),
      .almost_full_signal (almost_full_signal),
      .pop_signal         (pop_signal),
      .push_signal        (push_signal),
      .data_out           (data_out),
      .grant_id           (grant_id),
      .dbg_state_o        (dbg_state_o),
      .dbg_grant_o        (dbg_grant_o),
      .dbg_count_o        (dbg_count_o)
   );

   // ------------------------------------------------------------ source FIFOs
   // The empty flag covers the pop being issued this cycle. A FIFO holding
   // one word reads empty while that word is being popped.
   logic [W-1:0] src_mem [4][64];
   int           src_wr [4] = '{default: 0};
   int           src_rd [4] = '{default: 0};
   int           underflows = 0;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         empty_signal[i] = (src_wr[i] - src_rd[i] - int'(pop_signal[i])) <= 0;
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) src_rd[i] <= src_wr[i];
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (pop_signal[i]) begin
               if (src_wr[i] - src_rd[i] <= 0) begin
                  underflows <= underflows + 1;
               end else begin
                  data_in[i*W +: W] <= src_mem[i][src_rd[i] % 64];
                  src_rd[i]         <= src_rd[i] + 1;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------ model state
   logic [1:0]    exp_ids [$];   // expected pop order (queue index per pop)
   logic [W+17:0] exp_q   [$];   // {due cycle[15:0], id[1:0], data[W-1:0]}
   int            ld_cnt  [4];
   int            model_g = 0;   // last queue served, for round-robin entry

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // First queue holding words, scanning from, from+1, ... (mod 4).
   function automatic int next_queue(input int c[4], input int from);
      for (int k = 0; k < 4; k++) begin
         if (c[(from + k) % 4] > 0) return (from + k) % 4;
      end
      return from;
   endfunction

   // Pop order from fill levels, one whole burst at a time.
   task automatic build_expected();
      int c[4];
      int g;
      int used;
      int total;
      int n;
      total = 0;
      for (int i = 0; i < 4; i++) begin
         c[i]   = ld_cnt[i];
         total += c[i];
      end
      if (total == 0) return;
`ifdef REFEREE_STRICT_PRIO_EN
      g = next_queue(c, 0);
`else
      g = next_queue(c, model_g);
`endif
      used = 0;
      while (total > 0) begin
         if (c[g] > 0 && used < BL) begin
            n = (c[g] < BL - used) ? c[g] : BL - used;
            for (int j = 0; j < n; j++) exp_ids.push_back(2'(g));
            c[g]  -= n;
            used  += n;
            total -= n;
         end else begin
`ifdef REFEREE_STRICT_PRIO_EN
            g = next_queue(c, 0);
`else
            g = next_queue(c, (g + 1) % 4);
`endif
            used = 0;
         end
      end
      model_g = g;
   endtask

   // ------------------------------------------------------------ drivers
   task automatic do_reset();
      reset = 1'b1;
      almost_full_signal = 1'b0;
      exp_ids.delete();
      exp_q.delete();
      model_g = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic load(input int n0, input int n1, input int n2, input int n3);
      ld_cnt = '{n0, n1, n2, n3};
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < ld_cnt[i]; k++) begin
            src_mem[i][src_wr[i] % 64] = W'($urandom);
            src_wr[i]++;
         end
      end
   endtask

   // af_mode: 0 = never almost full, 1 = random, 2 = high for t in 10..14.
   // push_win counts pushes for t in 11..17.
   task automatic run_traffic(input int af_mode, input int max_cyc,
                              output int push_win);
      int            t;
      logic          af_prev;
      logic          af;
      logic          last_pop;
      logic [1:0]    id;
      logic [W+17:0] e;
      bit            done;
      t = 0; af_prev = 1'b0; last_pop = 1'b0; push_win = 0; done = 0;
      while (!done && t < max_cyc) begin
         @(negedge clk);
         check("burst_bound", 32'(dbg_count_o <= 4'(BL)), 32'd1);
         if (af_prev) check("pop_during_af", 32'(pop_signal), 32'd0);
         if (last_pop && !af_prev && exp_ids.size() > 0)
            check("no_bubble", 32'(pop_signal != 4'b0), 32'd1);
         if (pop_signal != 4'b0) begin
            check("pop_onehot", 32'($countones(pop_signal)), 32'd1);
            id = {pop_signal[3] | pop_signal[2], pop_signal[3] | pop_signal[1]};
            if (exp_ids.size() == 0) check("pop_extra", 32'(pop_signal), 32'd0);
            else check("pop_order", 32'(id), 32'(exp_ids.pop_front()));
            exp_q.push_back({16'(cyc + 2), id, src_mem[id][src_rd[id] % 64]});
         end
         last_pop = (pop_signal != 4'b0);
         if (push_signal) begin
            if (t >= 11 && t <= 17) push_win++;
            if (exp_q.size() == 0) begin
               check("push_extra", 32'(push_signal), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("push_latency", 32'(cyc), 32'(e[W+17:W+2]));
               check("push_grant_id", 32'(grant_id), 32'(e[W+1:W]));
               check("push_data", 32'(data_out), 32'(e[W-1:0]));
            end
         end
         case (af_mode)
            1:       af = ($urandom_range(0, 3) == 0);
            2:       af = (t >= 10 && t <= 14);
            default: af = 1'b0;
         endcase
         almost_full_signal = af;
         af_prev = af;
         t++;
         if (exp_ids.size() == 0 && exp_q.size() == 0) done = 1;
      end
      check("drain_complete", 32'(done), 32'd1);
      almost_full_signal = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("quiet_pop", 32'(pop_signal), 32'd0);
         check("quiet_push", 32'(push_signal), 32'd0);
      end
      check("idle_after_drain", 32'(dbg_state_o), 32'd0);
      check("no_underflow", 32'(underflows), 32'd0);
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      int  pw;
      int  n[4];
      bit  found;

      // Values held during reset.
      @(negedge clk);
      check("rst_pop", 32'(pop_signal), 32'd0);
      check("rst_push", 32'(push_signal), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_gid", 32'(grant_id), 32'd0);
      check("rst_state", 32'(dbg_state_o), 32'd0);
      check("rst_g", 32'(dbg_grant_o), 32'd0);
      check("rst_cnt", 32'(dbg_count_o), 32'd0);
      do_reset();

      // All queues empty: nothing moves, FSM stays idle.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_pop", 32'(pop_signal), 32'd0);
         check("idle_push", 32'(push_signal), 32'd0);
         check("idle_state", 32'(dbg_state_o), 32'd0);
      end

      // Queues 0 and 2 with six words each: fixed pop order.
      load(6, 0, 6, 0);
`ifdef REFEREE_STRICT_PRIO_EN
      exp_ids = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                  2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
`else
      exp_ids = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2,
                  2'd2, 2'd2, 2'd0, 2'd0, 2'd2, 2'd2};
`endif
      model_g = 2;
      run_traffic(0, 200, pw);

      // Queue 1 streaming with almost_full high for cycles 10..14.
      load(0, 30, 0, 0);
      build_expected();
      run_traffic(2, 300, pw);
      check("af_window_pushes", 32'(pw), 32'd2);

      // All four queues loaded.
      load(9, 6, 3, 5);
      build_expected();
      run_traffic(0, 300, pw);

      // Random fill levels with random almost_full.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 4; i++) n[i] = $urandom_range(0, 8);
         if (n[0] + n[1] + n[2] + n[3] == 0) n[$urandom_range(0, 3)] = 1;
         load(n[0], n[1], n[2], n[3]);
         build_expected();
         run_traffic(1, 400, pw);
      end

      // Reset one cycle after a pop to queue 3.
      do_reset();
      load(0, 0, 0, 5);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (pop_signal[3]) found = 1;
      end
      check("pop3_seen", 32'(found), 32'd1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async_pop", 32'(pop_signal), 32'd0);
      check("async_push", 32'(push_signal), 32'd0);
      check("async_data", 32'(data_out), 32'd0);
      check("async_gid", 32'(grant_id), 32'd0);
      check("async_cnt", 32'(dbg_count_o), 32'd0);
      check("async_g", 32'(dbg_grant_o), 32'd0);
      check("async_state", 32'(dbg_state_o), 32'd0);
      exp_ids.delete();
      exp_q.delete();
      model_g = 0;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("post_rst_push", 32'(push_signal), 32'd0);
      end
      load(3, 0, 0, 3);
      build_expected();
      check("restart_first", 32'(exp_ids[0]), 32'd0);
      run_traffic(0, 200, pw);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/referee_4to1_arb.md
REFEREE_4TO1_ARB -- requirements
Module: referee_4to1_arb

Interface
REQ-001 The block SHALL have parameter LINE_SIZE, default 12: data word width in bits.
REQ-002 The block SHALL have parameter BURST_LEN, default 4: maximum consecutive pops granted to one queue before rotation; legal range 1..15.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port empty_signal, input, 4: bit i high means source FIFO i is empty.
REQ-006 The block SHALL have port data_in, input, 4*LINE_SIZE: FIFO i read data on bits [i*LINE_SIZE +: LINE_SIZE], valid the cycle after pop.
REQ-007 The block SHALL have port almost_full_signal, input, 1: high means the destination FIFO can accept at most 2 more words.
REQ-008 The block SHALL have port pop_signal, output, 4: registered one-hot-or-zero read strobe to the source FIFOs.
REQ-009 The block SHALL have port push_signal, output, 1: registered write strobe to the destination FIFO.
REQ-010 The block SHALL have port data_out, output, LINE_SIZE: registered word written with push_signal.
REQ-011 The block SHALL have port grant_id, output, 2: index of the queue that sourced the current data_out.

Function
REQ-012 The FSM SHALL have states IDLE and SERVE, plus a 2-bit grant register g and a 4-bit burst counter.
REQ-013 In IDLE, when any empty_signal bit is low, the FSM SHALL select a queue per REQ-016, enter SERVE, and clear the burst counter.
REQ-014 In SERVE, pop_signal[g] SHALL be driven high for the next cycle iff empty_signal[g]=0, almost_full_signal=0, and burst count < BURST_LEN; each pop increments the counter.
REQ-015 While almost_full_signal=1, the FSM SHALL issue no pop, hold g, and hold the counter.
REQ-016 When queue g is empty or the counter reaches BURST_LEN, the FSM SHALL rotate to the first non-empty queue searching g+1, g+2, g+3, g (mod 4), clear the counter, and stay in SERVE; if all queues are empty it SHALL enter IDLE.
REQ-017 A rotation SHALL cost no bubble: the pop to the new queue is issued the cycle after the last pop to the old queue.
REQ-018 Latency: for pop_signal[i] high in cycle k, push_signal SHALL be high in cycle k+2, with data_out equal to the data_in slice i from cycle k+1 and grant_id = i.
REQ-019 Exactly one pop per cycle maximum; sustained throughput SHALL be 1 word per clock.
REQ-020 push_signal SHALL never be asserted without a matching earlier pop; in-flight words (at most 2) SHALL always be pushed even if almost_full_signal rises.
REQ-021 A queue whose empty_signal goes high in the same cycle a pop is decided SHALL NOT be popped.

Reset
REQ-022 While reset=1, pop_signal=0, push_signal=0, data_out=0, grant_id=0, g=0, counter=0, and state=IDLE; these values apply immediately, independent of clk.
REQ-023 Reset asserted mid-operation SHALL discard in-flight words; no push SHALL occur on the first edge after reset release.

Configuration
REQ-024 When the macro REFEREE_STRICT_PRIO_EN is defined, queue selection SHALL be the lowest-index non-empty queue, re-evaluated at each burst boundary or empty event, with BURST_LEN still bounding each grant.
REQ-025 When REFEREE_STRICT_PRIO_EN is undefined, round-robin selection per REQ-016 SHALL apply.

Verification
REQ-026 Reset, then all empty_signal=1 -> pop_signal=0 and push_signal=0 for 20 cycles, state IDLE.
REQ-027 Queues 0 and 2 each hold 6 words, BURST_LEN=4, round-robin -> pop order 0,0,0,0,2,2,2,2,0,0,2,2; pushes follow 2 cycles later with matching grant_id and data.
REQ-028 Queue 1 streaming, almost_full_signal high for cycles 10..14 -> no pops in cycles 11..15, at most 2 pushes after cycle 10, no data lost or duplicated.
REQ-029 All four queues non-empty with REFEREE_STRICT_PRIO_EN defined -> queue 0 receives bursts of 4 pops, queue 3 is popped only once queues 0..2 are empty.
REQ-030 Reset pulsed 1 cycle after a pop to queue 3 -> outputs go to 0 asynchronously, the in-flight word is never pushed, and arbitration restarts from queue 0.
